instr_encoder_fifo: RTL and testbench
=====================================

Name: instr_encoder_fifo

Overview:
- Encoder/issue side of the vector-processor instruction path: accepts one-hot operation requests plus an operand field, encodes them into 16-bit instructions (4-bit opcode in [15:12]) and buffers them in a small FIFO.
- Presents the buffered instructions with a valid/ready handshake to the fetch/decode stage, whose opcode decoder turns the opcode back into one-hot controls.
- Rejects malformed (non-one-hot) requests and counts them.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- OPW, 12, operand field width; instruction width is OPW+4.
- DROP_NOP, 0, when 1 a valid NOP request is accepted (handshake completes) but not enqueued.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_onehot  input  10  request, bit9..bit0 = VADD,VDOT,SMUL,SST,VLD,VST,SLL,SLH,J,NOP.
- req_operand  input  OPW  operand bits, placed in instr[OPW-1:0].
- req_valid  input  1  request present.
- req_ready  output  1  block can accept; = !full (combinational from registered count).
- out_instr  output  OPW+4  head instruction {opcode, operand}.
- out_valid  output  1  = !empty.
- out_ready  input  1  consumer takes head when out_valid && out_ready.
- err_pulse  output  1  one-cycle pulse, registered, for a rejected request.
- err_count  output  8  rejected-request counter, saturating at 255.
- level  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst high at clock edge): FIFO emptied, rd/wr pointers 0, level 0, out_valid 0, req_ready 1, err_pulse 0, err_count 0, out_instr = {4'b1111, 0}. Reset takes priority over every other event, including mid-handshake; in-flight entries are discarded.
- Encoding map (one-hot bit -> opcode): VADD 0000, VDOT 0001, SMUL 0010, SST 0011, VLD 0100, VST 0101, SLL 0110, SLH 0111, J 1000, NOP 1111. Opcodes 1001..1110 are never produced.
- Push: occurs when req_valid && req_ready.
  - Exactly one bit set: the instruction is written at wr_ptr and wr_ptr advances.
  - Exception: NOP with DROP_NOP=1 is accepted without a write.
- Rejection: when req_valid && req_ready and req_onehot has zero bits or more than one bit set:
  - No write occurs.
  - err_pulse = 1 in the following cycle.
  - err_count increments by 1 unless it is already 255.
  - The request still counts as consumed (handshake completes).
- While full: req_ready = 0. No push or error evaluation occurs; the requester must hold its request.
- Pop: occurs when out_valid && out_ready; rd_ptr advances.
- out_instr:
  - Always shows the entry at rd_ptr while non-empty.
  - Equals {4'b1111, 0} when empty.
  - Must not change while out_valid=1 and out_ready=0.
- Latency: a request accepted in cycle N appears on out_instr/out_valid in cycle N+1 at the earliest. There is no combinational bypass from req_* to out_*.
- Simultaneous push and pop:
  - Non-empty and not full: both happen and level is unchanged.
  - Empty: only the push happens, because out_valid=0 that cycle.
  - Full: only the pop happens, because req_ready=0 that cycle; req_ready rises the next cycle.
- Pointers wrap modulo DEPTH. level is in 0..DEPTH; full = (level==DEPTH), empty = (level==0).
- out_ready asserted while empty has no effect. req_onehot and req_operand are don't-care when req_valid=0.

Test Plan:
- Reset then single push: rst 1 for 2 cycles, then push req_onehot=10'b0000100000 (VLD), operand=12'hABC. Next cycle: out_valid=1, out_instr=16'h4ABC, level=1. Pop with out_ready=1: level=0, out_instr=16'hF000.
- Full encoding sweep: push all ten one-hot codes with operand 12'h001, draining continuously. Outputs in order: 0001,1001,2001,3001,4001,5001,6001,7001,8001,F001; err_count=0.
- Full/backpressure, DEPTH=4: out_ready=0, push 6 VADD requests with operands 1..6. After 4 accepts req_ready=0, level=4, out_instr stays 16'h0001. Raise out_ready: req_ready returns the cycle after the first pop; operands are drained in order 1..6 with none lost or duplicated.
- Errors: push req_onehot=10'b0 and then 10'b1100000000. Result: two err_pulse cycles, err_count=2, level=0. With 300 bad requests, err_count saturates at 255.
- Simultaneous push/pop at level=2: level stays 2 and output order is preserved across pointer wrap (run 20 mixed cycles against a scoreboard).
- DROP_NOP=1 and mid-operation reset: a NOP push gives no out_valid and level=0. With level=3, asserting rst for 1 cycle gives level=0, out_valid=0, err_count=0 on the next cycle.

Source files
------------

// File: rtl/instr_encoder_fifo.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_fifo
// Description : Issue side of the vector-processor instruction path. Encodes
//               one-hot operation requests plus an operand field into 16-bit
//               instructions ({opcode, operand}) and buffers them in a small
//               FIFO. Buffered instructions go to fetch/decode through a
//               valid/ready handshake. Malformed (non-one-hot) requests are
//               rejected, flagged with a one-cycle pulse and counted.
//
// Ports       : clk          - single clock, all state on the rising edge
//               rst          - synchronous active-high reset
//               req_onehot   - VADD,VDOT,SMUL,SST,VLD,VST,SLL,SLH,J,NOP (9..0)
//               req_operand  - operand field, placed in instr[OPW-1:0]
//               req_valid    - request present
//               req_ready    - block can accept (= not full)
//               out_instr    - head instruction, {4'b1111,0} while empty
//               out_valid    - FIFO not empty
//               out_ready    - consumer takes head when out_valid is high
//               err_pulse    - registered pulse for a rejected request
//               err_count    - rejected-request counter, saturates at 255
//               level        - current occupancy, 0..DEPTH
//
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_fifo #(
    parameter int DEPTH    = 4,
    parameter int OPW      = 12,
    parameter int DROP_NOP = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [9:0]                 req_onehot,
    input  logic [OPW-1:0]             req_operand,
    input  logic                       req_valid,
    output logic                       req_ready,
    output logic [OPW+3:0]             out_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       err_pulse,
    output logic [7:0]                 err_count,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = OPW + 4;

    localparam logic [LW-1:0] c_full_level = LW'(DEPTH);
    localparam logic [IW-1:0] c_idle_instr = {4'b1111, {OPW{1'b0}}};
    localparam logic [3:0]    c_op_nop     = 4'b1111;

    logic [IW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_err_pulse;
    logic [7:0]    r_err_count;

    logic [3:0]    w_opcode;
    logic          w_code_ok;
    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_reject;
    logic          w_nop_drop;

    // Encoder: the case enumerates every legal one-hot pattern, so anything
    // falling through to the default (zero bits or several bits) is malformed.
    always_comb begin
        w_opcode  = c_op_nop;
        w_code_ok = 1'b1;
        case (req_onehot)
            10'b10_0000_0000: w_opcode = 4'b0000;  // VADD
            10'b01_0000_0000: w_opcode = 4'b0001;  // VDOT
            10'b00_1000_0000: w_opcode = 4'b0010;  // SMUL
            10'b00_0100_0000: w_opcode = 4'b0011;  // SST
            10'b00_0010_0000: w_opcode = 4'b0100;  // VLD
            10'b00_0001_0000: w_opcode = 4'b0101;  // VST
            10'b00_0000_1000: w_opcode = 4'b0110;  // SLL
            10'b00_0000_0100: w_opcode = 4'b0111;  // SLH
            10'b00_0000_0010: w_opcode = 4'b1000;  // J
            10'b00_0000_0001: w_opcode = c_op_nop; // NOP
            default: begin
                w_opcode  = c_op_nop;
                w_code_ok = 1'b0;
            end
        endcase
    end

    assign w_full     = (r_level == c_full_level);
    assign w_empty    = (r_level == '0);
    assign w_accept   = req_valid && !w_full;
    assign w_nop_drop = (DROP_NOP != 0) && (req_onehot == 10'b00_0000_0001);
    assign w_push     = w_accept && w_code_ok && !w_nop_drop;
    assign w_reject   = w_accept && !w_code_ok;
    // Popping while empty is impossible since out_valid is low then.
    assign w_pop      = !w_empty && out_ready;

    // Storage needs no reset: entries are only visible between the write and
    // pointer bookkeeping, which is itself reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_opcode, req_operand};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= w_reject;
            if (w_reject && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    // The head slot is never the write target while data is present, so the
    // presented instruction stays stable under back-pressure.
    assign out_instr = w_empty ? c_idle_instr : r_mem[r_rd_ptr];
    assign out_valid = !w_empty;
    assign req_ready = !w_full;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign level     = r_level;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder_fifo
// Description : Self-checking bench for instr_encoder_fifo. A table of
//               single-request vectors with hand-computed instructions, then
//               queue-model sequences for back-pressure, errors, wrap-around,
//               mid-operation reset and NOP dropping (second instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_fifo;

    localparam int DEPTH = 4;
    localparam int OPW   = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  req_onehot = '0;
    logic [11:0] req_operand = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] out_instr;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        err_pulse;
    logic [7:0]  err_count;
    logic [2:0]  level;

    logic [9:0]  n_req_onehot = '0;
    logic [11:0] n_req_operand = '0;
    logic        n_req_valid = 1'b0;
    logic        n_req_ready;
    logic [15:0] n_out_instr;
    logic        n_out_valid;
    logic        n_out_ready = 1'b0;
    logic        n_err_pulse;
    logic [7:0]  n_err_count;
    logic [2:0]  n_level;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_q[$];
    int          m_errcnt = 0;

    always #5 clk = ~clk;

    instr_encoder_fifo #(.DEPTH(DEPTH), .OPW(OPW), .DROP_NOP(0)) dut (
        .clk(clk), .rst(rst),
        .req_onehot(req_onehot), .req_operand(req_operand),
        .req_valid(req_valid), .req_ready(req_ready),
        .out_instr(out_instr), .out_valid(out_valid), .out_ready(out_ready),
        .err_pulse(err_pulse), .err_count(err_count), .level(level)
    );

    instr_encoder_fifo #(.DEPTH(DEPTH), .OPW(OPW), .DROP_NOP(1)) dut_drop (
        .clk(clk), .rst(rst),
        .req_onehot(n_req_onehot), .req_operand(n_req_operand),
        .req_valid(n_req_valid), .req_ready(n_req_ready),
        .out_instr(n_out_instr), .out_valid(n_out_valid), .out_ready(n_out_ready),
        .err_pulse(n_err_pulse), .err_count(n_err_count), .level(n_level)
    );

    typedef struct {
        logic [9:0]  onehot;
        logic [11:0] operand;
        logic        exp_valid;
        logic [15:0] exp_instr;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference opcode map written out independently of the design.
    function automatic logic [4:0] ref_enc(input logic [9:0] oh);
        case (oh)
            10'h200: return {1'b1, 4'h0};
            10'h100: return {1'b1, 4'h1};
            10'h080: return {1'b1, 4'h2};
            10'h040: return {1'b1, 4'h3};
            10'h020: return {1'b1, 4'h4};
            10'h010: return {1'b1, 4'h5};
            10'h008: return {1'b1, 4'h6};
            10'h004: return {1'b1, 4'h7};
            10'h002: return {1'b1, 4'h8};
            10'h001: return {1'b1, 4'hF};
            default: return {1'b0, 4'hF};
        endcase
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1;
        req_valid = 1'b0;
        out_ready = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
        m_q.delete();
        m_errcnt = 0;
    endtask

    // One clock with the given inputs; the model predicts, then all outputs
    // are compared after the edge.
    task automatic cyc(input logic v, input logic [9:0] oh, input logic [11:0] opd,
                       input logic ordy, output logic accepted);
        logic [4:0] e;
        logic       m_pop;
        logic       m_err;
        req_valid   = v;
        req_onehot  = oh;
        req_operand = opd;
        out_ready   = ordy;
        e        = ref_enc(oh);
        accepted = v && (m_q.size() < DEPTH);
        m_pop    = (m_q.size() != 0) && ordy;
        m_err    = accepted && !e[4];
        if (m_pop) void'(m_q.pop_front());
        if (accepted && e[4]) m_q.push_back({e[3:0], opd});
        if (m_err && m_errcnt < 255) m_errcnt++;
        tick();
        req_valid = 1'b0;
        out_ready = 1'b0;
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        chk("out_instr", 32'(out_instr), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0000F000);
        chk("level", 32'(level), 32'(m_q.size()));
        chk("req_ready", 32'(req_ready), 32'(m_q.size() < DEPTH));
        chk("err_pulse", 32'(err_pulse), 32'(m_err));
        chk("err_count", 32'(err_count), 32'(m_errcnt));
    endtask

    initial begin
        logic acc;
        int   budget;
        logic [9:0] codes[10];

        vecs[0]  = '{10'h020, 12'hABC, 1'b1, 16'h4ABC, 1'b0};
        vecs[1]  = '{10'h200, 12'h001, 1'b1, 16'h0001, 1'b0};
        vecs[2]  = '{10'h100, 12'h001, 1'b1, 16'h1001, 1'b0};
        vecs[3]  = '{10'h080, 12'h001, 1'b1, 16'h2001, 1'b0};
        vecs[4]  = '{10'h040, 12'h001, 1'b1, 16'h3001, 1'b0};
        vecs[5]  = '{10'h020, 12'h001, 1'b1, 16'h4001, 1'b0};
        vecs[6]  = '{10'h010, 12'h001, 1'b1, 16'h5001, 1'b0};
        vecs[7]  = '{10'h008, 12'h001, 1'b1, 16'h6001, 1'b0};
        vecs[8]  = '{10'h004, 12'h001, 1'b1, 16'h7001, 1'b0};
        vecs[9]  = '{10'h002, 12'h001, 1'b1, 16'h8001, 1'b0};
        vecs[10] = '{10'h001, 12'h001, 1'b1, 16'hF001, 1'b0};
        vecs[11] = '{10'h000, 12'h123, 1'b0, 16'hF000, 1'b1};
        vecs[12] = '{10'h300, 12'h456, 1'b0, 16'hF000, 1'b1};
        vecs[13] = '{10'h3FF, 12'hFFF, 1'b0, 16'hF000, 1'b1};

        // Reset state
        do_reset(2);
        chk("rst level", 32'(level), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst err_pulse", 32'(err_pulse), 32'd0);
        chk("rst err_count", 32'(err_count), 32'd0);
        chk("rst out_instr", 32'(out_instr), 32'h0000F000);

        // Table: push one, check head, pop, check empty
        for (int i = 0; i < 14; i++) begin
            req_valid = 1'b1; req_onehot = vecs[i].onehot; req_operand = vecs[i].operand;
            tick();
            req_valid = 1'b0;
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d out_instr", i), 32'(out_instr), 32'(vecs[i].exp_instr));
            chk($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d err_pulse", i), 32'(err_pulse), 32'(vecs[i].exp_err));
            if (vecs[i].exp_err) m_errcnt++;
            chk($sformatf("vec%0d err_count", i), 32'(err_count), 32'(m_errcnt));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("vec%0d drained", i), 32'(level), 32'd0);
            chk($sformatf("vec%0d idle instr", i), 32'(out_instr), 32'h0000F000);
            chk($sformatf("vec%0d pulse end", i), 32'(err_pulse), 32'd0);
        end

        // Encoding sweep with continuous draining
        do_reset(1);
        for (int i = 0; i < 10; i++) codes[i] = vecs[i+1].onehot;
        for (int i = 0; i < 10; i++) cyc(1'b1, codes[i], 12'h001, 1'b1, acc);
        cyc(1'b0, 10'h0, 12'h0, 1'b1, acc);
        chk("sweep err_count", 32'(err_count), 32'd0);

        // Back-pressure: six VADD requests, consumer stalled
        do_reset(1);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 10'h200, 12'(k), 1'b0, acc);
            chk("bp accept", 32'(acc), 32'd1);
        end
        chk("bp full level", 32'(level), 32'd4);
        chk("bp full ready", 32'(req_ready), 32'd0);
        cyc(1'b1, 10'h200, 12'd5, 1'b0, acc);
        chk("bp held instr", 32'(out_instr), 32'h00000001);
        for (int k = 5; k <= 6; k++) begin
            budget = 0;
            do begin
                cyc(1'b1, 10'h200, 12'(k), 1'b1, acc);
                budget++;
            end while (!acc && budget < 10);
            chk("bp accept timeout", 32'(acc), 32'd1);
        end
        budget = 0;
        while (m_q.size() != 0 && budget < 20) begin
            cyc(1'b0, 10'h0, 12'h0, 1'b1, acc);
            budget++;
        end
        chk("bp drained", 32'(level), 32'd0);

        // Errors and saturation
        do_reset(1);
        cyc(1'b1, 10'h000, 12'h0, 1'b0, acc);
        cyc(1'b1, 10'h300, 12'h0, 1'b0, acc);
        cyc(1'b0, 10'h000, 12'h0, 1'b0, acc);
        chk("err two", 32'(err_count), 32'd2);
        for (int i = 0; i < 300; i++) cyc(1'b1, (i % 2) ? 10'h000 : 10'h0C0, 12'h0, 1'b0, acc);
        chk("err saturate", 32'(err_count), 32'd255);

        // Simultaneous push/pop at level 2, then mixed traffic across wraps
        do_reset(1);
        cyc(1'b1, 10'h100, 12'h011, 1'b0, acc);
        cyc(1'b1, 10'h080, 12'h022, 1'b0, acc);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 10'h1 << (i % 10), 12'(i + 12'h100), 1'b1, acc);
            chk("pp level2", 32'(level), 32'd2);
        end
        for (int i = 0; i < 40; i++)
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 10'h005 : (10'h1 << $urandom_range(0, 9)),
                12'($urandom), 1'($urandom_range(0, 1)), acc);

        // Mid-operation reset at level 3 with a non-zero error count
        do_reset(1);
        cyc(1'b1, 10'h000, 12'h0, 1'b0, acc);
        for (int i = 0; i < 3; i++) cyc(1'b1, 10'h008, 12'(i), 1'b0, acc);
        chk("pre-rst level", 32'(level), 32'd3);
        do_reset(1);
        chk("mid-rst level", 32'(level), 32'd0);
        chk("mid-rst out_valid", 32'(out_valid), 32'd0);
        chk("mid-rst err_count", 32'(err_count), 32'd0);
        chk("mid-rst out_instr", 32'(out_instr), 32'h0000F000);

        // DROP_NOP instance
        n_req_valid = 1'b1; n_req_onehot = 10'h001; n_req_operand = 12'h777;
        tick();
        n_req_valid = 1'b0;
        chk("drop nop valid", 32'(n_out_valid), 32'd0);
        chk("drop nop level", 32'(n_level), 32'd0);
        chk("drop nop err", 32'(n_err_pulse), 32'd0);
        n_req_valid = 1'b1; n_req_onehot = 10'h002; n_req_operand = 12'h777;
        tick();
        n_req_valid = 1'b0;
        chk("drop j instr", 32'(n_out_instr), 32'h00008777);
        chk("drop j level", 32'(n_level), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
